arc4_encrypt: RTL
=================

Name: arc4_encrypt

Overview:
ARC4 encryptor and the writer side of the length-prefixed ciphertext memory that the cracker reads. It takes a 24-bit key and a length-prefixed plaintext in PT memory. It writes a length-prefixed ciphertext, byte 0 = length and bytes 1..L = data, into CT memory. It also produces the test images for the cracker datapath and runs on-chip as the encryption front end.

Parameters:
KEY_BYTES, 3, key bytes; key width = 8*KEY_BYTES; key byte 0 = most-significant byte.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  start request; sampled only when rdy=1
rdy  out  1  high when idle and able to accept en
key  in  8*KEY_BYTES  ARC4 key; latched when en is accepted
pt_addr  out  8  PT memory address; synchronous read, data valid the cycle after the address
pt_rddata  in  8  PT memory read data
ct_addr  out  8  CT memory write address
ct_wrdata  out  8  CT memory write data
ct_wren  out  1  CT write strobe; one write per cycle in which it is high

Behaviour:
- Reset (async, rst=1): state=IDLE, rdy=1, ct_wren=0, ct_addr=0, ct_wrdata=0, pt_addr=0, i=j=0. Reset mid-operation aborts immediately. Bytes already written stay in CT memory; no further writes occur.
- Internal S-box: 256x8 register file with two combinational read ports and two write ports (held in arc4_sbox).
- Handshake: en is accepted in cycle 0 only if rdy=1. rdy drops in cycle 1. key is latched in cycle 0. en while rdy=0 is ignored; it is neither queued nor a restart.
- States and timing, relative to accept cycle 0:
  - INIT, cycles 1..256: S[i]=i, i=0..255.
  - KSA, cycles 257..512: one i per cycle. j=j+S[i]+kb[i mod KEY_BYTES], then swap S[i],S[j]. kb index comes from a wrapping counter, not a divider. All sums are mod 256.
  - LEN_RD, cycle 513: pt_addr=0. i and j are reset to 0.
  - LEN_WR, cycle 514: L=pt_rddata latched. Write ct[0]=L (ct_wren=1, ct_addr=0). If L=0, go to DONE.
  - Byte k, k=1..L, takes two cycles:
    - P_SWAP, cycle 513+2k: i=i+1, j=j+S[i], swap S[i],S[j], pt_addr=k.
    - P_OUT, cycle 514+2k: pad=S[(S[i]+S[j]) mod 256] read from the post-swap S. ct[k]=pad XOR pt_rddata, with ct_wren=1 and ct_addr=k.
  - DONE: rdy=1 in cycle 515+2L, return to IDLE. Total busy time is 514+2L cycles; L=0 gives rdy high in cycle 515.
- ct_wren is high only in LEN_WR and P_OUT cycles. All other cycles have ct_wren=0, and ct_addr/ct_wrdata hold their last value.
- L=255 is the maximum. Addresses never wrap; ct_addr reaches 255 and stops.
- PT memory must be stable while rdy=0. Content changes while busy are undefined.
- Back-to-back use is allowed: en may be asserted in the same cycle rdy rises, and INIT restarts the S-box.

Decomposition:
- Package arc4_pkg: state enum (IDLE, INIT, KSA, LEN_RD, LEN_WR, P_SWAP, P_OUT, DONE), SBOX_SIZE=256, byte typedef.
- Sub-module arc4_sbox: 256x8 register file, 2 async read ports, 2 write ports. Simultaneous writes to the same address: port B wins, which only occurs when i==j and both write the same value.
- Top level: FSM, i/j/k counters, key-byte counter, XOR.

Test Plan:
- Known vector: key=4B6579 ("Key"), PT = 09,"Plaintext" → CT = 09,BB,F3,16,E8,D9,40,AF,0A,D3. rdy high at cycle 533, exactly 10 writes.
- Empty message: PT[0]=00 → single write ct[0]=00, rdy high at cycle 515, no further ct_wren.
- Round trip: encrypt a 73-byte printable PT with key 000003, then copy CT to PT and re-encrypt with the same key → output equals the original PT byte-for-byte. Feeding the first CT to the cracker yields key=000003, key_valid=1.
- Max length: L=255 random PT, key=FFFFFF → 256 writes, last at ct_addr=FF, rdy at cycle 1025, no address wrap.
- Handshake: en pulsed at cycles 5 and 300 of a busy run → second pulse ignored, exactly one run. Key changed after accept does not affect output.
- Reset mid-run: assert rst during P_OUT of byte 4 → rdy=1 and ct_wren=0 immediately, no writes after. A fresh en then produces the correct full output.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 encryptor: FSM state encoding, S-box size, byte type.
package arc4_pkg;

   localparam int SBOX_SIZE = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      KSA    = 3'd2,
      LEN_RD = 3'd3,
      LEN_WR = 3'd4,
      P_SWAP = 3'd5,
      P_OUT  = 3'd6,
      DONE   = 3'd7
   } state_e;

endpackage

// File: rtl/arc4_sbox.sv
// ARC4 state array: 256x8 register file, two combinational read ports and two
// write ports. When both ports write the same address, port B wins; the FSM
// only does this when i==j, where both ports carry the same value.
module arc4_sbox
   import arc4_pkg::*;
(
   input  logic  clk,
   input  byte_t ra_addr,
   output byte_t ra_data,
   input  byte_t rb_addr,
   output byte_t rb_data,
   input  logic  wa_en,
   input  byte_t wa_addr,
   input  byte_t wa_data,
   input  logic  wb_en,
   input  byte_t wb_addr,
   input  byte_t wb_data
);

   byte_t mem_q [SBOX_SIZE];

   assign ra_data = mem_q[ra_addr];
   assign rb_data = mem_q[rb_addr];

   // Contents are rebuilt by INIT on every run, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (wa_en) mem_q[wa_addr] <= wa_data;
      if (wb_en) mem_q[wb_addr] <= wb_data;
   end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext from PT memory and writes
// the length-prefixed ciphertext into CT memory. One S-box init pass, one KSA
// pass, then two cycles per data byte (swap, then keystream XOR + write).
module arc4_encrypt
   import arc4_pkg::*;
#(
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             pt_addr,
   input  logic [7:0]             pt_rddata,
   output logic [7:0]             ct_addr,
   output logic [7:0]             ct_wrdata,
   output logic                   ct_wren
);

   localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KIW-1:0] KI_LAST = KIW'(KEY_BYTES - 1);

   state_e                 state_q, state_d;
   byte_t                  i_q, i_d;
   byte_t                  j_q, j_d;
   byte_t                  t_q, t_d;        // pad index S[i]+S[j], formed during the swap
   byte_t                  len_q, len_d;
   logic [KIW-1:0]         kidx_q, kidx_d;  // key byte selector, wraps at KEY_BYTES
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic                   rdy_q, rdy_d;
   byte_t                  pt_addr_q, pt_addr_d;  // doubles as the byte index k
   byte_t                  ct_addr_q, ct_addr_d;
   logic                   ct_wren_q, ct_wren_d;
   byte_t                  ct_wrdata_q, ct_wrdata_d;  // last written byte, held between writes

   byte_t ra, rb, rd_a, rd_b;
   logic  wa_en, wb_en;
   byte_t wa_addr, wa_data, wb_addr, wb_data;
   byte_t kb, wr_byte;
   logic  accept;

   arc4_sbox u_sbox (
      .clk     (clk),
      .ra_addr (ra),
      .ra_data (rd_a),
      .rb_addr (rb),
      .rb_data (rd_b),
      .wa_en   (wa_en),
      .wa_addr (wa_addr),
      .wa_data (wa_data),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   assign accept = en && rdy_q;

   // Current key byte; byte 0 is the most-significant byte of the key.
   always_comb begin
      kb = key_q[8*(KEY_BYTES-1-int'(kidx_q)) +: 8];
   end

   // Read port A: S[i] during KSA, S[i+1] during the swap, S[t] for the pad.
   always_comb begin
      ra = i_q;
      case (state_q)
         P_SWAP:  ra = i_q + 8'd1;
         P_OUT:   ra = t_q;
         default: ra = i_q;
      endcase
   end

   // Read port B: S at the new j, which depends on the port A read.
   always_comb begin
      rb = j_q;
      case (state_q)
         KSA:     rb = j_q + rd_a + kb;
         P_SWAP:  rb = j_q + rd_a;
         default: rb = j_q;
      endcase
   end

   // Byte presented on a write cycle: the length, or keystream XOR plaintext.
   always_comb begin
      wr_byte = (state_q == P_OUT) ? (rd_a ^ pt_rddata) : pt_rddata;
   end

   assign ct_wrdata = ct_wren_q ? wr_byte : ct_wrdata_q;

   // Next-state logic for the FSM, counters, S-box writes and CT strobes.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      t_d         = t_q;
      len_d       = len_q;
      kidx_d      = kidx_q;
      key_d       = key_q;
      rdy_d       = rdy_q;
      pt_addr_d   = pt_addr_q;
      ct_addr_d   = ct_addr_q;
      ct_wren_d   = 1'b0;
      ct_wrdata_d = ct_wren_q ? wr_byte : ct_wrdata_q;
      wa_en       = 1'b0;
      wa_addr     = i_q;
      wa_data     = rd_b;
      wb_en       = 1'b0;
      wb_addr     = rb;
      wb_data     = rd_a;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = INIT;
               rdy_d   = 1'b0;
               key_d   = key;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         INIT: begin
            wa_en   = 1'b1;
            wa_addr = i_q;
            wa_data = i_q;
            i_d     = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               state_d = KSA;
               j_d     = 8'd0;
               kidx_d  = '0;
            end
         end
         KSA: begin
            // swap S[i] and S[j'] with j' = j + S[i] + kb
            wa_en   = 1'b1;
            wa_addr = i_q;
            wa_data = rd_b;
            wb_en   = 1'b1;
            wb_addr = rb;
            wb_data = rd_a;
            i_d     = i_q + 8'd1;
            j_d     = rb;
            kidx_d  = (kidx_q == KI_LAST) ? '0 : kidx_q + 1'b1;
            if (i_q == 8'hFF) begin
               state_d   = LEN_RD;
               i_d       = 8'd0;
               j_d       = 8'd0;
               pt_addr_d = 8'd0;
            end
         end
         LEN_RD: begin
            state_d   = LEN_WR;
            ct_wren_d = 1'b1;
            ct_addr_d = 8'd0;
         end
         LEN_WR: begin
            len_d = pt_rddata;
            if (pt_rddata == 8'd0) begin
               state_d = DONE;
               rdy_d   = 1'b1;
            end else begin
               state_d   = P_SWAP;
               pt_addr_d = 8'd1;
            end
         end
         P_SWAP: begin
            // i' = i+1, j' = j + S[i'], swap; pad index uses pre-swap values
            wa_en     = 1'b1;
            wa_addr   = i_q + 8'd1;
            wa_data   = rd_b;
            wb_en     = 1'b1;
            wb_addr   = rb;
            wb_data   = rd_a;
            i_d       = i_q + 8'd1;
            j_d       = rb;
            t_d       = rd_a + rd_b;
            state_d   = P_OUT;
            ct_wren_d = 1'b1;
            ct_addr_d = pt_addr_q;
         end
         P_OUT: begin
            if (pt_addr_q == len_q) begin
               state_d = DONE;
               rdy_d   = 1'b1;
            end else begin
               state_d   = P_SWAP;
               pt_addr_d = pt_addr_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         t_q         <= 8'd0;
         len_q       <= 8'd0;
         kidx_q      <= '0;
         key_q       <= '0;
         rdy_q       <= 1'b1;
         pt_addr_q   <= 8'd0;
         ct_addr_q   <= 8'd0;
         ct_wren_q   <= 1'b0;
         ct_wrdata_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         t_q         <= t_d;
         len_q       <= len_d;
         kidx_q      <= kidx_d;
         key_q       <= key_d;
         rdy_q       <= rdy_d;
         pt_addr_q   <= pt_addr_d;
         ct_addr_q   <= ct_addr_d;
         ct_wren_q   <= ct_wren_d;
         ct_wrdata_q <= ct_wrdata_d;
      end
   end

   assign rdy     = rdy_q;
   assign pt_addr = pt_addr_q;
   assign ct_addr = ct_addr_q;
   assign ct_wren = ct_wren_q;

endmodule
